// File: rtl/i2s_playback_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : i2s_playback_serializer
//  Description : Takes signed stereo sample pairs over a valid/ready handshake
//                and serialises them as an I2S playback stream (pbclk, pblrc,
//                pbdat), all derived from mclk. Repeats the previous pair and
//                flags an underrun when no new pair is available at frame start.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_playback_serializer #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32,
    parameter int DATA_BITS = 16
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] sample_l,
    input  logic [DATA_BITS-1:0] sample_r,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 pbclk,
    output logic                 pblrc,
    output logic                 pbdat,
    output logic                 frame_start,
    output logic                 underrun,
    output logic                 underrun_sticky
);

    localparam int c_frame_len = 2 * SLOT_BITS * BCLK_DIV;
    localparam int c_cnt_w     = $clog2(c_frame_len);

    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(c_frame_len - 1);
    localparam logic [c_cnt_w-1:0] c_half     = c_cnt_w'(c_frame_len / 2);
    localparam logic [c_cnt_w-1:0] c_div      = c_cnt_w'(BCLK_DIV);
    localparam logic [c_cnt_w-1:0] c_div_half = c_cnt_w'(BCLK_DIV / 2);

    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_frame_wrap;
    logic [c_cnt_w-1:0]   w_bit_idx;
    logic [DATA_BITS-1:0] w_word;
    logic                 w_pbclk_nxt;
    logic                 w_pblrc_nxt;
    logic                 w_pbdat_nxt;
    logic                 w_accept;

    logic [DATA_BITS-1:0] r_hold_l;
    logic [DATA_BITS-1:0] r_hold_r;
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_shift_l;
    logic [DATA_BITS-1:0] r_shift_r;

    logic r_pbclk;
    logic r_pblrc;
    logic r_pbdat;
    logic r_frame_start;
    logic r_underrun;
    logic r_underrun_sticky;

    // Ready is combinational so a pair can be taken in the very cycle the
    // holding register empties (n = 0).
    assign sample_ready = ~r_hold_full;
    assign w_accept     = sample_valid & ~r_hold_full;

    // Next-count decode: every registered output is computed from the count
    // the frame is about to enter, so outputs line up with cnt in each cycle.
    always_comb begin
        w_frame_wrap = (r_cnt == c_cnt_max);
        w_cnt_nxt    = w_frame_wrap ? '0 : r_cnt + c_cnt_w'(1);
        w_pbclk_nxt  = ((w_cnt_nxt % c_div) >= c_div_half);
        w_pblrc_nxt  = (w_cnt_nxt >= c_half);
        w_bit_idx    = (w_cnt_nxt % c_half) / c_div;
        w_word       = w_pblrc_nxt ? r_shift_r : r_shift_l;
        // Slot bit 0 is the I2S one-bit delay; bits 1..DATA_BITS carry the
        // word MSB first; everything after is zero padding.
        w_pbdat_nxt  = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (w_bit_idx == c_cnt_w'(i + 1)) begin
                w_pbdat_nxt = w_word[DATA_BITS-1-i];
            end
        end
    end

    // Free-running frame counter and registered serial outputs.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_pbclk       <= 1'b0;
            r_pblrc       <= 1'b0;
            r_pbdat       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_pbclk       <= w_pbclk_nxt;
            r_pblrc       <= w_pblrc_nxt;
            r_pbdat       <= w_pbdat_nxt;
            r_frame_start <= w_frame_wrap;
        end
    end

    // Holding register and frame load; an empty hold at the frame edge keeps
    // the old shift contents (repeat) and raises the underrun flags. A pair
    // accepted on that same edge stays held for the following frame.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_hold_l          <= '0;
            r_hold_r          <= '0;
            r_hold_full       <= 1'b0;
            r_shift_l         <= '0;
            r_shift_r         <= '0;
            r_underrun        <= 1'b0;
            r_underrun_sticky <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_frame_wrap && r_hold_full) begin
                r_shift_l   <= r_hold_l;
                r_shift_r   <= r_hold_r;
                r_hold_full <= 1'b0;
            end else begin
                if (w_frame_wrap) begin
                    r_underrun        <= 1'b1;
                    r_underrun_sticky <= 1'b1;
                end
                if (w_accept) begin
                    r_hold_l    <= sample_l;
                    r_hold_r    <= sample_r;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end

    assign pbclk           = r_pbclk;
    assign pblrc           = r_pblrc;
    assign pbdat           = r_pbdat;
    assign frame_start     = r_frame_start;
    assign underrun        = r_underrun;
    assign underrun_sticky = r_underrun_sticky;

endmodule
`default_nettype wire

// File: tb/tb_i2s_playback_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2s_playback_serializer
//  Description : Directed self-checking bench for i2s_playback_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_playback_serializer;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        pbclk;
    logic        pblrc;
    logic        pbdat;
    logic        frame_start;
    logic        underrun;
    logic        underrun_sticky;

    i2s_playback_serializer #(
        .BCLK_DIV  (4),
        .SLOT_BITS (32),
        .DATA_BITS (16)
    ) dut (
        .mclk            (mclk),
        .rst             (rst),
        .sample_l        (sample_l),
        .sample_r        (sample_r),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .pbclk           (pbclk),
        .pblrc           (pblrc),
        .pbdat           (pbdat),
        .frame_start     (frame_start),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky)
    );

    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;
    int tn;
    int k = 0;

    // Reference frame position, tracked independently of the DUT.
    always @(posedge mclk or posedge rst) begin
        if (rst) tn <= 0;
        else     tn <= (tn == 255) ? 0 : tn + 1;
    end

    // Per-frame observations collected by scan_frame.
    int          s_fs, s_ur, s_clk_hi, s_lrc_hi, s_dat_ones, s_acc, s_acc_bad, s_rdy_lo;
    logic [3:0]  s_clk_pat;
    logic [1:0]  s_lrc_edge;
    logic [31:0] s_lw0, s_lw3, s_rw0, s_rw3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int t);
        int g;
        g = 0;
        while (tn != t && g < 300) begin
            @(negedge mclk);
            g++;
        end
        if (tn != t) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_n: observed position %0d expected %0d", tn, t);
        end
    endtask

    // Walks one whole frame from n = 0, sampling every cycle on the falling
    // edge; slot words are captured at the first and last mclk of each bit.
    // With stream set, sample_valid stays high and data advances after each accept.
    task automatic scan_frame(input bit stream);
        bit pend;
        pend = 1'b0;
        s_fs = 0; s_ur = 0; s_clk_hi = 0; s_lrc_hi = 0; s_dat_ones = 0;
        s_acc = 0; s_acc_bad = 0; s_rdy_lo = 0;
        s_clk_pat = '0; s_lrc_edge = '0;
        s_lw0 = '0; s_lw3 = '0; s_rw0 = '0; s_rw3 = '0;
        for (int i = 0; i < 256; i++) begin
            int b;
            b = (i % 128) / 4;
            if (pend) begin
                k++;
                sample_l = 16'h0100 + 16'(k);
                sample_r = 16'h0200 + 16'(k);
                pend = 1'b0;
            end
            if (frame_start)   s_fs++;
            if (underrun)      s_ur++;
            if (pbclk)         s_clk_hi++;
            if (pblrc)         s_lrc_hi++;
            if (pbdat)         s_dat_ones++;
            if (!sample_ready) s_rdy_lo++;
            if (i < 4)    s_clk_pat[3-i] = pbclk;
            if (i == 127) s_lrc_edge[1]  = pblrc;
            if (i == 128) s_lrc_edge[0]  = pblrc;
            if (i % 4 == 0) begin
                if (i < 128) s_lw0[31-b] = pbdat;
                else         s_rw0[31-b] = pbdat;
            end
            if (i % 4 == 3) begin
                if (i < 128) s_lw3[31-b] = pbdat;
                else         s_rw3[31-b] = pbdat;
            end
            if (stream && sample_valid && sample_ready) begin
                pend = 1'b1;
                s_acc++;
                if (i != 0) s_acc_bad++;
            end
            @(negedge mclk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge mclk);
        chk("rst_pbclk", 32'(pbclk), 32'd0);
        chk("rst_pblrc", 32'(pblrc), 32'd0);
        chk("rst_pbdat", 32'(pbdat), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_ur", 32'(underrun), 32'd0);
        chk("rst_sticky", 32'(underrun_sticky), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);

        // 1: idle, no samples ever offered
        rst = 1'b0;
        chk("first_fs", 32'(frame_start), 32'd0);
        wait_n(255);
        chk("f0_sticky", 32'(underrun_sticky), 32'd0);
        @(negedge mclk);
        scan_frame(1'b0);
        chk("idle_fs", 32'(s_fs), 32'd1);
        chk("idle_ur", 32'(s_ur), 32'd1);
        chk("idle_clk_pat", 32'(s_clk_pat), 32'h3);
        chk("idle_clk_hi", 32'(s_clk_hi), 32'd128);
        chk("idle_lrc_edge", 32'(s_lrc_edge), 32'h1);
        chk("idle_lrc_hi", 32'(s_lrc_hi), 32'd128);
        chk("idle_dat", 32'(s_dat_ones), 32'd0);
        chk("idle_sticky", 32'(underrun_sticky), 32'd1);

        // 2: one pair pushed mid-frame
        wait_n(50);
        sample_l = 16'h8001; sample_r = 16'h7FFE; sample_valid = 1'b1;
        chk("t2_ready_pre", 32'(sample_ready), 32'd1);
        @(negedge mclk);
        sample_valid = 1'b0;
        chk("t2_ready_post", 32'(sample_ready), 32'd0);
        wait_n(0);
        chk("t2_ready_n0", 32'(sample_ready), 32'd1);
        scan_frame(1'b0);
        chk("t2_ur", 32'(s_ur), 32'd0);
        chk("t2_l0", s_lw0, 32'h4000_8000);
        chk("t2_l3", s_lw3, 32'h4000_8000);
        chk("t2_r0", s_rw0, 32'h3FFF_0000);
        chk("t2_r3", s_rw3, 32'h3FFF_0000);

        // 3: single pair, then starvation -> repeat
        wait_n(10);
        sample_l = 16'h1234; sample_r = 16'hABCD; sample_valid = 1'b1;
        @(negedge mclk);
        sample_valid = 1'b0;
        wait_n(0);
        scan_frame(1'b0);
        chk("t3a_ur", 32'(s_ur), 32'd0);
        chk("t3a_l", s_lw0, 32'h091A_0000);
        chk("t3a_r", s_rw0, 32'h55E6_8000);
        scan_frame(1'b0);
        chk("t3b_ur", 32'(s_ur), 32'd1);
        chk("t3b_l", s_lw3, 32'h091A_0000);
        chk("t3b_r", s_rw3, 32'h55E6_8000);

        // 4: continuous valid with incrementing data
        k = 0;
        sample_l = 16'h0100; sample_r = 16'h0200; sample_valid = 1'b1;
        scan_frame(1'b1);
        chk("t4a_acc", 32'(s_acc), 32'd1);
        chk("t4a_acc_pos", 32'(s_acc_bad), 32'd0);
        chk("t4a_ur", 32'(s_ur), 32'd1);
        chk("t4a_l", s_lw0, 32'h091A_0000);
        chk("t4a_rdy_lo", 32'(s_rdy_lo), 32'd255);
        scan_frame(1'b1);
        chk("t4b_acc", 32'(s_acc), 32'd1);
        chk("t4b_acc_pos", 32'(s_acc_bad), 32'd0);
        chk("t4b_ur", 32'(s_ur), 32'd0);
        chk("t4b_l", s_lw0, 32'h0080_0000);
        chk("t4b_r", s_rw0, 32'h0100_0000);
        chk("t4b_rdy_lo", 32'(s_rdy_lo), 32'd255);
        scan_frame(1'b1);
        sample_valid = 1'b0;
        chk("t4c_acc", 32'(s_acc), 32'd1);
        chk("t4c_l", s_lw0, 32'h0080_8000);
        chk("t4c_r", s_rw0, 32'h0100_8000);

        // 5: offer arrives with hold empty in the last cycle of the frame
        wait_n(255);
        chk("t5_ready", 32'(sample_ready), 32'd1);
        sample_l = 16'h5A5A; sample_r = 16'hA5A5; sample_valid = 1'b1;
        @(negedge mclk);
        sample_valid = 1'b0;
        chk("t5_ur", 32'(underrun), 32'd1);
        chk("t5_fs", 32'(frame_start), 32'd1);
        chk("t5_ready_n0", 32'(sample_ready), 32'd0);
        scan_frame(1'b0);
        chk("t5a_ur", 32'(s_ur), 32'd1);
        chk("t5a_l", s_lw0, 32'h0081_0000);
        chk("t5a_r", s_rw0, 32'h0101_0000);
        chk("t5a_rdy_lo", 32'(s_rdy_lo), 32'd256);
        scan_frame(1'b0);
        chk("t5b_ur", 32'(s_ur), 32'd0);
        chk("t5b_l", s_lw3, 32'h2D2D_0000);
        chk("t5b_r", s_rw3, 32'h52D2_8000);

        // 6: reset in the middle of the left slot
        wait_n(70);
        chk("t6_pbclk_pre", 32'(pbclk), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_pbclk", 32'(pbclk), 32'd0);
        chk("t6_pblrc", 32'(pblrc), 32'd0);
        chk("t6_pbdat", 32'(pbdat), 32'd0);
        chk("t6_sticky", 32'(underrun_sticky), 32'd0);
        chk("t6_ready", 32'(sample_ready), 32'd1);
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        scan_frame(1'b0);
        chk("t6_fs", 32'(s_fs), 32'd0);
        chk("t6_ur", 32'(s_ur), 32'd0);
        chk("t6_clk_pat", 32'(s_clk_pat), 32'h3);
        chk("t6_lrc_edge", 32'(s_lrc_edge), 32'h1);
        chk("t6_lrc_hi", 32'(s_lrc_hi), 32'd128);
        chk("t6_l", s_lw0, 32'h0);
        chk("t6_r", s_rw0, 32'h0);
        chk("t6_next_fs", 32'(frame_start), 32'd1);
        chk("t6_next_ur", 32'(underrun), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
